// File: rtl/gpo_access_arbiter.sv
// Round-robin arbiter sharing the GPO Avalon-MM slave (0=data, 4=bit-set,
// 5=bit-clear) between NUM_REQ requesters. Each granted op becomes one
// single-cycle slave access followed by a one-cycle ack pulse.
module gpo_access_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [2:0]                gpo_address,
  output logic                      gpo_chipselect,
  output logic                      gpo_write_n,
  output logic [31:0]               gpo_writedata,
  input  logic [31:0]               gpo_readdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   grant, grant_nxt;
  logic [1:0]         op_q, op_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic [DATA_W-1:0]  rsp_nxt;
  logic               busy_nxt;
  logic               cs_nxt;
  logic               wn_nxt;
  logic [2:0]         addr_nxt;
  logic [31:0]        wd_nxt;

  logic               found;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   sel;
  logic [1:0]         sel_op;
  logic [DATA_W-1:0]  sel_data;

  // Only the low DATA_W bits of the slave read bus carry GPO state.
  logic               unused_rd;
  assign unused_rd = ^gpo_readdata;

  // Pick the first pending request after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Route the selected requester's op and data.
  always_comb begin
    sel_op   = OP_WRITE;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == sel) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next state and next registered outputs; bus idles unless entering ISSUE.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    op_nxt     = op_q;
    ack_nxt    = '0;
    rsp_nxt    = rsp_data;
    cs_nxt     = 1'b0;
    wn_nxt     = 1'b1;
    addr_nxt   = 3'd0;
    wd_nxt     = 32'd0;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = ISSUE;
          rr_ptr_nxt = sel;
          grant_nxt  = sel;
          op_nxt     = sel_op;
          cs_nxt     = 1'b1;
          unique case (sel_op)
            OP_WRITE: begin addr_nxt = 3'd0; wn_nxt = 1'b0; wd_nxt = 32'(sel_data); end
            OP_SET:   begin addr_nxt = 3'd4; wn_nxt = 1'b0; wd_nxt = 32'(sel_data); end
            OP_CLEAR: begin addr_nxt = 3'd5; wn_nxt = 1'b0; wd_nxt = 32'(sel_data); end
            default:  begin addr_nxt = 3'd0; wn_nxt = 1'b1; wd_nxt = 32'd0;          end
          endcase
        end
      end
      ISSUE: begin
        state_nxt      = ACK;
        ack_nxt[grant] = 1'b1;
        if (op_q == OP_READ) begin
          rsp_nxt = gpo_readdata[DATA_W-1:0];
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= IDX_W'(NUM_REQ - 1);
      grant          <= '0;
      op_q           <= OP_WRITE;
      ack            <= '0;
      rsp_data       <= '0;
      busy           <= 1'b0;
      gpo_chipselect <= 1'b0;
      gpo_write_n    <= 1'b1;
      gpo_address    <= 3'd0;
      gpo_writedata  <= 32'd0;
    end else begin
      state          <= state_nxt;
      rr_ptr         <= rr_ptr_nxt;
      grant          <= grant_nxt;
      op_q           <= op_nxt;
      ack            <= ack_nxt;
      rsp_data       <= rsp_nxt;
      busy           <= busy_nxt;
      gpo_chipselect <= cs_nxt;
      gpo_write_n    <= wn_nxt;
      gpo_address    <= addr_nxt;
      gpo_writedata  <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_gpo_access_arbiter.sv
// Scoreboard bench for gpo_access_arbiter: expected accesses are queued when
// a request is driven and checked when the bus access / ack appears.
module tb_gpo_access_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [47:0] req_data;
  logic [3:0]  ack;
  logic [11:0] rsp_data;
  logic        busy;
  logic [2:0]  gpo_address;
  logic        gpo_chipselect;
  logic        gpo_write_n;
  logic [31:0] gpo_writedata;
  logic [31:0] gpo_readdata;

  gpo_access_arbiter #(.NUM_REQ(4), .DATA_W(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_op         (req_op),
    .req_data       (req_data),
    .ack            (ack),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .gpo_address    (gpo_address),
    .gpo_chipselect (gpo_chipselect),
    .gpo_write_n    (gpo_write_n),
    .gpo_writedata  (gpo_writedata),
    .gpo_readdata   (gpo_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple GPO slave: data register with bit-set / bit-clear aliases.
  logic [11:0] gpo_q = 12'h000;
  assign gpo_readdata = {20'h0, gpo_q};
  always @(posedge clk) begin
    if (gpo_chipselect && !gpo_write_n) begin
      case (gpo_address)
        3'd0:    gpo_q <= gpo_writedata[11:0];
        3'd4:    gpo_q <= gpo_q | gpo_writedata[11:0];
        3'd5:    gpo_q <= gpo_q & ~gpo_writedata[11:0];
        default: gpo_q <= gpo_q;
      endcase
    end
  end

  typedef struct {
    int          idx;
    logic [2:0]  addr;
    logic        wn;
    logic [31:0] wd;
    logic [11:0] rsp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [11:0] exp_rsp  = 12'h000;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_slot(input int i, input logic [1:0] op, input logic [11:0] d);
    req_op[2*i +: 2]    = op;
    req_data[12*i +: 12] = d;
  endtask

  function automatic exp_t mk_exp(input int idx, input logic [1:0] op,
                                  input logic [11:0] d, input logic [11:0] rsp);
    exp_t e;
    e.idx = idx;
    e.rsp = rsp;
    e.wn  = (op == 2'b11);
    e.wd  = (op == 2'b11) ? 32'h0 : {20'h0, d};
    case (op)
      2'b01:   e.addr = 3'd4;
      2'b10:   e.addr = 3'd5;
      default: e.addr = 3'd0;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_op = '0; req_data = '0;
    step(); step();
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl ack=%b busy=%b expected ack=0000 busy=0", ack, busy);
    end
    checks++;
    if (rsp_data !== 12'h0) begin
      failures++;
      $display("FAIL reset_rsp rsp_data=%h expected 000", rsp_data);
    end
    checks++;
    if (gpo_chipselect !== 1'b0 || gpo_write_n !== 1'b1 || gpo_address !== 3'd0 || gpo_writedata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus cs=%b wn=%b addr=%0d wd=%h expected cs=0 wn=1 addr=0 wd=0",
               gpo_chipselect, gpo_write_n, gpo_address, gpo_writedata);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_contention();
    exp_t       e;
    logic [3:0] raise;
    int         acks, last;
    for (int i = 0; i < 4; i++) set_slot(i, 2'b00, 12'h100 + 12'(i));
    foreach (sb_q[k]) sb_q.delete(k);
    for (int n = 0; n < 5; n++) sb_q.push_back(mk_exp(n % 4, 2'b00, 12'h100 + 12'(n % 4), exp_rsp));
    req = 4'b1111;
    raise = '0; acks = 0; last = 0;
    for (int c = 0; c < 40 && acks < 5; c++) begin
      step();
      if (raise != '0) begin req = req | raise; raise = '0; end
      if (gpo_chipselect) begin
        checks++;
        if (sb_q.size() == 0 || {gpo_address, gpo_write_n, gpo_writedata} !== {sb_q[0].addr, sb_q[0].wn, sb_q[0].wd}) begin
          failures++;
          $display("FAIL contention_bus addr=%0d wn=%b wd=%h queued=%0d", gpo_address, gpo_write_n, gpo_writedata, sb_q.size());
        end
      end
      if (ack != '0) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL contention_ack unexpected ack=%b", ack);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (ack !== onehot(e.idx) || rsp_data !== e.rsp) begin
            failures++;
            $display("FAIL contention_ack ack=%b rsp=%h expected ack=%b rsp=%h", ack, rsp_data, onehot(e.idx), e.rsp);
          end
        end
        if (acks > 0) begin
          checks++;
          if (cyc - last != 3) begin
            failures++;
            $display("FAIL contention_gap gap=%0d expected 3", cyc - last);
          end
        end
        last = cyc;
        acks++;
        raise = (acks < 5) ? ack : 4'b0;
        req = (acks < 5) ? (req & ~ack) : 4'b0;
      end
    end
    if (acks != 5) begin
      checks++; failures++;
      $display("FAIL contention_timeout acks=%0d expected 5", acks);
    end
    req = '0;
    step();
  endtask

  task automatic test_single_write();
    exp_t e;
    int   start, busy_cnt;
    logic got;
    set_slot(1, 2'b00, 12'hA5A);
    sb_q.push_back(mk_exp(1, 2'b00, 12'hA5A, exp_rsp));
    req = 4'b0010;
    start = cyc; busy_cnt = 0; got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (busy) busy_cnt++;
      if (gpo_chipselect) begin
        checks++;
        if (cyc != start + 1 || gpo_address !== 3'd0 || gpo_write_n !== 1'b0 || gpo_writedata !== 32'h00000A5A) begin
          failures++;
          $display("FAIL write_bus at=%0d addr=%0d wn=%b wd=%h expected at=%0d addr=0 wn=0 wd=00000a5a",
                   cyc - start, gpo_address, gpo_write_n, gpo_writedata, 1);
        end
      end
      if (ack != '0 && sb_q.size() > 0) begin
        got = 1'b1;
        e = sb_q.pop_front();
        checks++;
        if (ack !== onehot(e.idx) || cyc != start + 2) begin
          failures++;
          $display("FAIL write_ack ack=%b at=%0d expected ack=%b at=2", ack, cyc - start, onehot(e.idx));
        end
        req = '0;
      end
    end
    checks++;
    if (!got || busy_cnt != 2) begin
      failures++;
      $display("FAIL write_busy got_ack=%b busy_cycles=%0d expected 1 and 2", got, busy_cnt);
    end
  endtask

  task automatic test_set_clear_read();
    exp_t        e;
    logic        got;
    logic [1:0]  ops [4];
    logic [11:0] dat [4];
    ops = '{2'b00, 2'b01, 2'b10, 2'b11};
    dat = '{12'h000, 12'h0F0, 12'h030, 12'h000};
    for (int n = 0; n < 4; n++) begin
      if (ops[n] == 2'b11) exp_rsp = 12'h0C0;
      set_slot(0, ops[n], dat[n]);
      sb_q.push_back(mk_exp(0, ops[n], dat[n], exp_rsp));
      req = 4'b0001;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        step();
        if (gpo_chipselect) begin
          checks++;
          if (sb_q.size() == 0 || {gpo_address, gpo_write_n, gpo_writedata} !== {sb_q[0].addr, sb_q[0].wn, sb_q[0].wd}) begin
            failures++;
            $display("FAIL scr_bus op=%0d addr=%0d wn=%b wd=%h", n, gpo_address, gpo_write_n, gpo_writedata);
          end
        end
        if (ack != '0 && sb_q.size() > 0) begin
          got = 1'b1;
          e = sb_q.pop_front();
          checks++;
          if (ack !== onehot(e.idx) || rsp_data !== e.rsp) begin
            failures++;
            $display("FAIL scr_ack op=%0d ack=%b rsp=%h expected ack=%b rsp=%h", n, ack, rsp_data, onehot(e.idx), e.rsp);
          end
          req = '0;
        end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL scr_timeout op=%0d no ack", n);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [3:0] raise, mask;
    int         acks, want;
    set_slot(0, 2'b00, 12'h011);
    set_slot(3, 2'b00, 12'h033);
    for (int ph = 0; ph < 2; ph++) begin
      mask = (ph == 0) ? 4'b1000 : 4'b1001;
      want = (ph == 0) ? 1 : 3;
      if (ph == 0) begin
        sb_q.push_back(mk_exp(3, 2'b00, 12'h033, exp_rsp));
      end else begin
        sb_q.push_back(mk_exp(0, 2'b00, 12'h011, exp_rsp));
        sb_q.push_back(mk_exp(3, 2'b00, 12'h033, exp_rsp));
        sb_q.push_back(mk_exp(0, 2'b00, 12'h011, exp_rsp));
      end
      req = mask; raise = '0; acks = 0;
      for (int c = 0; c < 20 && acks < want; c++) begin
        step();
        if (raise != '0) begin req = req | raise; raise = '0; end
        if (gpo_chipselect) begin
          checks++;
          if (sb_q.size() == 0 || {gpo_address, gpo_write_n, gpo_writedata} !== {sb_q[0].addr, sb_q[0].wn, sb_q[0].wd}) begin
            failures++;
            $display("FAIL wrap_bus ph=%0d addr=%0d wn=%b wd=%h", ph, gpo_address, gpo_write_n, gpo_writedata);
          end
        end
        if (ack != '0 && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++;
          if (ack !== onehot(e.idx)) begin
            failures++;
            $display("FAIL wrap_grant ph=%0d ack=%b expected %b", ph, ack, onehot(e.idx));
          end
          acks++;
          raise = (acks < want) ? ack : 4'b0;
          req = (acks < want) ? (req & ~ack) : 4'b0;
        end
      end
      if (acks != want) begin
        checks++; failures++;
        $display("FAIL wrap_timeout ph=%0d acks=%0d expected %0d", ph, acks, want);
      end
      req = '0;
      step();
    end
  endtask

  task automatic test_late_drop();
    exp_t e;
    logic got;
    int   extra_cs;
    set_slot(2, 2'b01, 12'h001);
    sb_q.push_back(mk_exp(2, 2'b01, 12'h001, exp_rsp));
    req = 4'b0100;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      if (gpo_chipselect) begin
        req = '0;
        checks++;
        if (sb_q.size() == 0 || {gpo_address, gpo_write_n, gpo_writedata} !== {sb_q[0].addr, sb_q[0].wn, sb_q[0].wd}) begin
          failures++;
          $display("FAIL late_bus addr=%0d wn=%b wd=%h", gpo_address, gpo_write_n, gpo_writedata);
        end
      end
      if (ack != '0 && sb_q.size() > 0) begin
        got = 1'b1;
        e = sb_q.pop_front();
        checks++;
        if (ack !== onehot(e.idx)) begin
          failures++;
          $display("FAIL late_ack ack=%b expected %b", ack, onehot(e.idx));
        end
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL late_timeout no ack");
    end
    extra_cs = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (gpo_chipselect || ack != '0) extra_cs++;
    end
    checks++;
    if (extra_cs != 0) begin
      failures++;
      $display("FAIL late_regrant activity_cycles=%0d expected 0", extra_cs);
    end
  endtask

  task automatic test_reset_mid_issue();
    exp_t e;
    logic seen, got;
    int   ack_seen;
    set_slot(0, 2'b00, 12'h0FF);
    sb_q.push_back(mk_exp(0, 2'b00, 12'h0FF, exp_rsp));
    req = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (gpo_chipselect) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL rstmid_timeout no access");
    end
    reset = 1'b1;
    req = '0;
    #1;
    checks++;
    if (gpo_chipselect !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async cs=%b busy=%b expected 0 0", gpo_chipselect, busy);
    end
    foreach (sb_q[k]) sb_q.delete(k);
    exp_rsp = 12'h000;
    ack_seen = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (ack != '0) ack_seen++;
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (ack != '0) ack_seen++;
    end
    checks++;
    if (ack_seen != 0 || rsp_data !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_noack ack_cycles=%0d rsp=%h expected 0 000", ack_seen, rsp_data);
    end
    set_slot(1, 2'b00, 12'h055);
    set_slot(2, 2'b00, 12'h0AA);
    sb_q.push_back(mk_exp(1, 2'b00, 12'h055, exp_rsp));
    req = 4'b0110;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      if (gpo_chipselect) begin
        checks++;
        if (sb_q.size() == 0 || {gpo_address, gpo_write_n, gpo_writedata} !== {sb_q[0].addr, sb_q[0].wn, sb_q[0].wd}) begin
          failures++;
          $display("FAIL rstmid_bus addr=%0d wn=%b wd=%h", gpo_address, gpo_write_n, gpo_writedata);
        end
      end
      if (ack != '0 && sb_q.size() > 0) begin
        got = 1'b1;
        e = sb_q.pop_front();
        checks++;
        if (ack !== onehot(e.idx)) begin
          failures++;
          $display("FAIL rstmid_grant ack=%b expected %b", ack, onehot(e.idx));
        end
        req = '0;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL rstmid_grant_timeout no ack");
    end
    step();
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_op   = '0;
    req_data = '0;
    test_reset();
    test_contention();
    test_single_write();
    test_set_clear_read();
    test_wrap();
    test_late_drop();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
